systolic_seq_ctrl: RTL and testbench

- Sequencer that feeds an N-wide, DEPTH-deep systolic array of 1-bit registered cells.
- Per job: clears the array, accepts a counted burst of input vectors over a valid/ready handshake, and skews each vector bit onto the array columns as a diagonal wavefront.
- Drains the pipeline and deskews the array outputs back into aligned output vectors.
- Sits between the top-level I/O (`ui_in`/`uo_out`) and the cell array; it owns every array enable and clear.

---
 rtl/systolic_pkg.sv | 24 ++
 rtl/skew_line.sv | 38 +++
 rtl/systolic_seq_ctrl.sv | 105 ++++++++++
 tb/tb_systolic_seq_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: constants shared by the systolic sequencer slice.
//   - default array geometry (N_DEF, DEPTH_DEF) and the resulting beat latency
//   - FSM state encodings
//   - cnt_w(): width of a counter that has to hold 0..l
package systolic_pkg;

  localparam int N_DEF     = 8;
  localparam int DEPTH_DEF = 8;
  // Every bit sees j skew + DEPTH array + (N-1-j) deskew stages.
  localparam int L_DEF     = DEPTH_DEF + N_DEF - 1;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_FEED  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic int cnt_w(input int l);
    return (l < 1) ? 1 : $clog2(l + 1);
  endfunction

endpackage

// File: rtl/skew_line.sv
// skew_line: 1-bit delay line of STAGES registers that only shift on en.
//   clk, rst_n : clock, async active-low reset
//   en         : advance the line by one stage
//   clr        : synchronous clear of every stage (wins over en)
//   d, q       : line input / output; STAGES == 0 makes q a plain wire
module skew_line #(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_wire
      assign q = d;
      logic unused;
      assign unused = &{1'b0, clk, rst_n, en, clr};
    end else begin : g_line
      logic [STAGES-1:0] sr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr <= '0;
        end else if (clr) begin
          sr <= '0;
        end else if (en) begin
          sr[0] <= d;
          for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
        end
      end
      assign q = sr[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: job sequencer for an N-wide, DEPTH-deep array of 1-bit
// registered cells. Per job it clears the array, takes `len` beats over
// valid/ready, skews them onto the columns, drains, and deskews results.
//   start/len          : job request (sampled in IDLE), beat count
//   in_valid/in_ready  : input beat handshake, in_data the vector
//   arr_in/arr_en/arr_clr/arr_out : array-side column data, enable, clear
//   out_valid/out_data : aligned output pulse and vector (no backpressure)
//   busy/done          : not-IDLE flag, one-cycle job-complete pulse
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic [N-1:0]     arr_in,
  output logic             arr_en,
  output logic             arr_clr,
  input  logic [N-1:0]     arr_out,
  output logic             out_valid,
  output logic [N-1:0]     out_data,
  output logic             busy,
  output logic             done
);

  localparam int L  = DEPTH + N - 1;
  localparam int CW = cnt_w(L);

  state_t           state;
  logic [LEN_W-1:0] rem;
  logic [CW-1:0]    dcnt;
  logic             accept;
  logic [N-1:0]     gin;
  logic             tok_q;

  assign in_ready = (state == ST_FEED);
  assign accept   = in_valid & in_ready;
  // Everything downstream holds on FEED bubbles; DRAIN always advances.
  assign arr_en   = accept | (state == ST_DRAIN);
  assign arr_clr  = (state == ST_CLEAR);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  // Gating with accept is also what injects zeros while draining.
  assign gin      = in_data & {N{accept}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      rem   <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          rem   <= len;
          state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          dcnt  <= '0;
          state <= (rem != '0) ? ST_FEED : ST_DONE;
        end
        ST_FEED: if (accept) begin
          rem <= rem - 1'b1;
          if (rem == LEN_W'(1)) begin
            dcnt  <= '0;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == CW'(L - 1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Column j: j stages in, N-1-j stages out, so every bit totals L.
  for (genvar j = 0; j < N; j++) begin : g_col
    skew_line #(.STAGES(j)) u_skew (
      .clk(clk), .rst_n(rst_n), .en(arr_en), .clr(arr_clr),
      .d(gin[j]), .q(arr_in[j])
    );
    skew_line #(.STAGES(N - 1 - j)) u_deskew (
      .clk(clk), .rst_n(rst_n), .en(arr_en), .clr(arr_clr),
      .d(arr_out[j]), .q(out_data[j])
    );
  end

  skew_line #(.STAGES(L)) u_token (
    .clk(clk), .rst_n(rst_n), .en(arr_en), .clr(arr_clr),
    .d(accept), .q(tok_q)
  );

  // A token parked in the last stage only counts on a cycle that advances.
  assign out_valid = tok_q & arr_en;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: table of job vectors plus a mid-job reset sequence.
// Accepted beats go into a scoreboard queue; each out_valid pops and compares.
// The array is modelled as DEPTH enabled, clearable registers per column.
module tb_systolic_seq_ctrl;
  localparam int N = 8, DEPTH = 8, LEN_W = 4;
  localparam int NONE = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_data = '0;
  logic [N-1:0]     arr_in;
  logic             arr_en, arr_clr;
  logic [N-1:0]     arr_out;
  logic             out_valid;
  logic [N-1:0]     out_data;
  logic             busy, done;

  int checks = 0;
  int failures = 0;
  logic [N-1:0] sb[$];

  always #5 clk = ~clk;

  systolic_seq_ctrl #(.N(N), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .arr_in(arr_in), .arr_en(arr_en), .arr_clr(arr_clr), .arr_out(arr_out),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done)
  );

  // Array model: identity data path of DEPTH registers per column.
  logic [N-1:0] arr_q [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) arr_q[i] <= '0;
    end else if (arr_clr) begin
      for (int i = 0; i < DEPTH; i++) arr_q[i] <= '0;
    end else if (arr_en) begin
      arr_q[0] <= arr_in;
      for (int i = 1; i < DEPTH; i++) arr_q[i] <= arr_q[i-1];
    end
  end
  assign arr_out = arr_q[DEPTH-1];

  typedef struct {
    int             len;
    logic [3:0][7:0] d;    // beat data
    logic [3:0][7:0] acc;  // cycle each beat is offered (and must be taken)
    logic [3:0][7:0] oc;   // cycle each output is expected
    int             done_c;
    int             restart; // extra start pulse cycle, NONE if unused
  } vec_t;

  vec_t tbl[5];
  vec_t v5a;

  task automatic chk(input string name, input int c, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v);
    int bi, oi, last_acc;
    logic exp_ov;
    logic [N-1:0] e;
    bi = 0; oi = 0;
    sb.delete();
    last_acc = (v.len > 0) ? int'(v.acc[v.len-1]) : -1;
    for (int c = 0; c <= v.done_c + 1; c++) begin
      @(posedge clk); #1;
      start    = (c == 0) || (c == v.restart);
      len      = LEN_W'(v.len);
      in_valid = (bi < v.len) && (int'(v.acc[bi]) == c);
      in_data  = in_valid ? v.d[bi] : N'($urandom);
      @(negedge clk);
      chk("in_ready", c, 32'(in_ready), 32'(v.len > 0 && c >= 2 && c <= last_acc));
      chk("arr_clr", c, 32'(arr_clr), 32'(c == 1));
      chk("busy", c, 32'(busy), 32'(c >= 1 && c <= v.done_c));
      chk("done", c, 32'(done), 32'(c == v.done_c));
      if (in_valid && in_ready) begin
        sb.push_back(v.d[bi]);
        bi++;
      end
      exp_ov = (oi < v.len) && (int'(v.oc[oi]) == c);
      chk("out_valid", c, 32'(out_valid), 32'(exp_ov));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", c, 32'(0), 32'(1));
        end else begin
          e = sb.pop_front();
          chk("out_data", c, 32'(out_data), 32'(e));
        end
        oi++;
      end
    end
    start = 1'b0; in_valid = 1'b0;
    chk("beats_in", v.done_c, 32'(bi), 32'(v.len));
    chk("beats_out", v.done_c, 32'(oi), 32'(v.len));
  endtask

  initial begin
    // single beat
    tbl[0] = '{len:1, d:{8'h0, 8'h0, 8'h0, 8'hA5}, acc:{8'd0, 8'd0, 8'd0, 8'd2},
               oc:{8'd0, 8'd0, 8'd0, 8'd17}, done_c:18, restart:NONE};
    // burst
    tbl[1] = '{len:4, d:{8'h80, 8'h04, 8'h02, 8'h01}, acc:{8'd5, 8'd4, 8'd3, 8'd2},
               oc:{8'd20, 8'd19, 8'd18, 8'd17}, done_c:21, restart:NONE};
    // stall in cycles 3-4
    tbl[2] = '{len:2, d:{8'h0, 8'h0, 8'hC3, 8'h3C}, acc:{8'd0, 8'd0, 8'd5, 8'd2},
               oc:{8'd0, 8'd0, 8'd20, 8'd19}, done_c:21, restart:NONE};
    // zero length
    tbl[3] = '{len:0, d:'0, acc:'0, oc:'0, done_c:2, restart:NONE};
    // start re-pulsed mid-job is ignored
    tbl[4] = '{len:1, d:{8'h0, 8'h0, 8'h0, 8'hA5}, acc:{8'd0, 8'd0, 8'd0, 8'd2},
               oc:{8'd0, 8'd0, 8'd0, 8'd17}, done_c:18, restart:5};
    v5a    = '{len:1, d:{8'h0, 8'h0, 8'h0, 8'h5A}, acc:{8'd0, 8'd0, 8'd0, 8'd2},
               oc:{8'd0, 8'd0, 8'd0, 8'd17}, done_c:18, restart:NONE};

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_outs", 0, {in_ready, arr_en, arr_clr, out_valid, busy, done, arr_in, out_data},
        32'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 0, 32'(busy), 32'(0));

    for (int t = 0; t < 5; t++) run_job(tbl[t]);

    // reset in cycle 8 of a len=4 job (during DRAIN)
    for (int c = 0; c <= 8; c++) begin
      @(posedge clk); #1;
      start    = (c == 0);
      len      = 4'd4;
      in_valid = (c >= 2 && c <= 5);
      in_data  = N'(8'h11 << (c % 4));
      if (c == 8) rst_n = 1'b0;
      @(negedge clk);
      if (c == 7) chk("pre_rst_busy", c, 32'(busy), 32'(1));
    end
    chk("midrst_outs", 8, {in_ready, arr_en, arr_clr, out_valid, busy, done, arr_in, out_data},
        32'(0));
    start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 0, 32'(done), 32'(0));
    run_job(v5a);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
